// File: rtl/fxp_mac_sequencer_pkg.sv
// Shared definitions for the fixed-point MAC sequencer: word length, FSM encoding and
// the sign-magnitude full-scale magnitude.
package fxp_mac_sequencer_pkg;

  localparam int unsigned REG_WORD_LEN = 16;

  // Largest representable magnitude at the default word length.
  localparam logic [REG_WORD_LEN-2:0] MAG_MAX = '1;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StMul   = 3'd2,
    StAcc   = 3'd3,
    StDone  = 3'd4
  } state_e;

endpackage

// File: rtl/fxp_sm_sat_add.sv
// Combinational sign-magnitude adder; the magnitude saturates to full scale and o_ovf flags it.
module fxp_sm_sat_add
  import fxp_mac_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = REG_WORD_LEN
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_ovf
);

  localparam logic [WIDTH-2:0] MagMax = '1;

  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-2:0] w_ma;
  logic [WIDTH-2:0] w_mb;
  logic [WIDTH-2:0] w_mag;
  logic [WIDTH-1:0] w_wide;
  logic             w_sign;

  assign w_sa = i_a[WIDTH-1];
  assign w_sb = i_b[WIDTH-1];
  assign w_ma = i_a[WIDTH-2:0];
  assign w_mb = i_b[WIDTH-2:0];

  always_comb begin
    o_ovf  = 1'b0;
    w_wide = '0;
    w_sign = w_sa;
    w_mag  = '0;
    if (w_sa == w_sb) begin
      w_wide = {1'b0, w_ma} + {1'b0, w_mb};
      if (w_wide[WIDTH-1]) begin
        w_mag = MagMax;
        o_ovf = 1'b1;
      end else begin
        w_mag = w_wide[WIDTH-2:0];
      end
    end else if (w_ma >= w_mb) begin
      w_mag = w_ma - w_mb;
    end else begin
      w_mag  = w_mb - w_ma;
      w_sign = w_sb;
    end
    // No negative zero.
    o_sum = {w_sign & (w_mag != '0), w_mag};
  end

endmodule

// File: rtl/fxp_mac_sequencer.sv
// Sequenced dot product: per tap FETCH -> MUL -> ACC with one Q(WIDTH-1) multiplier and a
// saturating sign-magnitude accumulator; start/busy/done handshake, all outputs registered.
module fxp_mac_sequencer
  import fxp_mac_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH   = REG_WORD_LEN,
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned ADDR_W  = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W:0]   i_len,
  output logic              o_busy,
  output logic              o_done,
  output logic [WIDTH-1:0]  o_result,
  output logic              o_ovf,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [WIDTH-1:0]  i_coef_data,
  input  logic [WIDTH-1:0]  i_samp_data
);

  localparam logic [ADDR_W:0] MaxLen = (ADDR_W + 1)'(MAX_LEN);

  state_e              r_state;
  state_e              w_state_d;
  logic [WIDTH-1:0]    r_acc;
  logic [WIDTH-1:0]    w_acc_d;
  logic [WIDTH-1:0]    r_p;
  logic [WIDTH-1:0]    w_p_d;
  logic [WIDTH-1:0]    r_result;
  logic [WIDTH-1:0]    w_result_d;
  logic [ADDR_W-1:0]   r_i;
  logic [ADDR_W-1:0]   w_i_d;
  logic [ADDR_W-1:0]   r_last;
  logic [ADDR_W-1:0]   w_last_d;
  logic                r_ovf;
  logic                w_ovf_d;
  logic                r_busy;
  logic                r_done;
  logic                r_rd_en;
  logic [ADDR_W:0]     w_len_c;
  logic [WIDTH-1:0]    w_sum;
  logic                w_add_ovf;
  logic [2*WIDTH-3:0]  w_prod_full;
  logic [WIDTH-2:0]    w_prod_mag;
  logic                w_prod_sign;

  assign w_len_c = (i_len > MaxLen) ? MaxLen : i_len;

  assign w_prod_full = i_coef_data[WIDTH-2:0] * i_samp_data[WIDTH-2:0];
  assign w_prod_mag  = (WIDTH - 1)'(w_prod_full >> (WIDTH - 1));
  assign w_prod_sign = (i_coef_data[WIDTH-1] ^ i_samp_data[WIDTH-1]) & (w_prod_mag != '0);

  fxp_sm_sat_add #(
    .WIDTH(WIDTH)
  ) u_sat_add (
    .i_a  (r_acc),
    .i_b  (r_p),
    .o_sum(w_sum),
    .o_ovf(w_add_ovf)
  );

  always_comb begin
    w_state_d  = r_state;
    w_acc_d    = r_acc;
    w_p_d      = r_p;
    w_i_d      = r_i;
    w_last_d   = r_last;
    w_ovf_d    = r_ovf;
    w_result_d = r_result;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_acc_d   = '0;
          w_ovf_d   = 1'b0;
          w_i_d     = '0;
          // Low bits of a full-length count wrap to index MAX_LEN-1.
          w_last_d  = w_len_c[ADDR_W-1:0] - ADDR_W'(1);
          w_state_d = (w_len_c == '0) ? StDone : StFetch;
        end
      end
      StFetch: w_state_d = StMul;
      StMul: begin
        w_p_d     = {w_prod_sign, w_prod_mag};
        w_state_d = StAcc;
      end
      StAcc: begin
        w_acc_d = w_sum;
        w_ovf_d = r_ovf | w_add_ovf;
        if (r_i == r_last) begin
          w_state_d = StDone;
        end else begin
          w_i_d     = r_i + ADDR_W'(1);
          w_state_d = StFetch;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    // Load on entry so result is already valid in the DONE cycle.
    if (w_state_d == StDone && r_state != StDone) begin
      w_result_d = w_acc_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_acc    <= '0;
      r_p      <= '0;
      r_result <= '0;
      r_i      <= '0;
      r_last   <= '0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_rd_en  <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_acc    <= w_acc_d;
      r_p      <= w_p_d;
      r_result <= w_result_d;
      r_i      <= w_i_d;
      r_last   <= w_last_d;
      r_ovf    <= w_ovf_d;
      r_busy   <= (w_state_d == StFetch) || (w_state_d == StMul) || (w_state_d == StAcc);
      r_done   <= (w_state_d == StDone);
      r_rd_en  <= (w_state_d == StFetch);
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_result  = r_result;
  assign o_ovf     = r_ovf;
  assign o_rd_en   = r_rd_en;
  assign o_rd_addr = r_i;

endmodule
